i2c_word_writer: RTL and testbench
==================================

Name: i2c_word_writer

Overview:
- Serializing end of the codec configuration handshake.
- Accepts a 24-bit word (device address byte, register byte, data byte) on DATA when GO rises. Shifts it out MSB-first as one I2C write transaction on an open-drain SCLK/SDAT pair.
- Returns END high when the bus is idle again, so the upstream sequencer advances its ROM address on END's rising edge.

Parameters:
- CLK_DIV, 16, CLOCK cycles per SCL quarter-period (SCL period = 4*CLK_DIV); legal range 2..65535.
- IDLE_GAP, 8, quarter-periods SCL/SDA held released after STOP before END rises.

Ports:
- CLOCK  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- GO  in  1  start request; rising edge sampled while idle launches a transfer.
- DATA  in  24  word to send; captured on the accepted GO edge.
- END  out  1  1 = idle/complete, 0 = transfer in progress.
- ACK_ERR  out  1  sticky NACK flag; cleared at next accepted GO.
- I2C_SCLK  out  1  SCL level (1 = released).
- I2C_SDAT_OE  out  1  1 = drive SDA low, 0 = release.
- I2C_SDAT_IN  in  1  sampled SDA pin level.

Behaviour:
- Reset (async, any state):
  - END=1, ACK_ERR=0, I2C_SCLK=1, I2C_SDAT_OE=0.
  - FSM=IDLE, quarter counter=0, bit index=0, GO edge register=0.
  - Reset mid-transfer releases the bus immediately. No STOP is generated.
- Quarter tick: a free-running divider counts 0..CLK_DIV-1 and pulses qtick for one cycle at CLK_DIV-1. The divider is zeroed on GO acceptance so the first tick is exactly CLK_DIV cycles later.
- GO edge detect: registered GO_d; accept when GO & ~GO_d & FSM==IDLE.
  - GO edges in any other state are ignored.
  - GO held high produces no repeat.
- Cycle of acceptance: latch DATA into a 24-bit shift register, END<=0, ACK_ERR<=0, FSM<=START.
- START, 2 qticks: q0 SDA low with SCL high; q1 SCL low.
- BIT, 27 slots in order: 8 data, ACK, 8 data, ACK, 8 data, ACK. Each slot has 4 qticks:
  - q0: set SDA. Data slot: OE = ~shreg[23]. ACK slot: OE = 0.
  - q1: SCL high.
  - q2: sample I2C_SDAT_IN. In ACK slots, sample 1 = NACK.
  - q3: SCL low. Data slots shift left by 1.
- STOP, 3 qticks: q0 OE=1 (SDA low); q1 SCL high; q2 OE=0 (SDA rises with SCL high).
- GAP: wait IDLE_GAP qticks with bus released, then END<=1 on the following CLOCK edge and FSM<=IDLE.
- Total latency from GO acceptance to END rising:
  - (2 + 27*4 + 3 + IDLE_GAP) * CLK_DIV cycles, +1.
  - Defaults: 121*16 + 1 = 1937 cycles.
- END is registered, glitch-free, and changes only on the accept cycle and the GAP exit.
- Shift register width is exactly 24; no bits beyond bit 23 are referenced.
- Bit index counts 0..26 and resets to 0 on entry to START. No wrap-around occurs mid-transfer.
- SDA is never changed while SCL is high, except for the START/STOP edges.

Optional Feature:
I2C_ACK_CHECK_EN
- Defined:
  - A NACK in any ACK slot sets ACK_ERR=1 at q2.
  - After q3 of that slot, FSM jumps to STOP; remaining bytes are skipped.
  - END still rises after STOP + GAP.
  - Latency is shortened accordingly, e.g. NACK on the first ACK gives (2 + 9*4 + 3 + IDLE_GAP)*CLK_DIV + 1.
- Not defined:
  - ACK slots still release SDA and pulse SCL, but the sample is discarded.
  - ACK_ERR is tied 0.
  - All 27 slots are always sent.

Test Plan:
1. Reset during BIT slot 5 -> same cycle: I2C_SCLK=1, I2C_SDAT_OE=0, END=1. Next GO edge starts a fresh transfer from START.
2. CLK_DIV=4, IDLE_GAP=8, DATA=24'h340C00, slave model ACKs every byte, GO edge -> checks:
   - Decoded bytes 34,0C,00; START then STOP observed.
   - END low for exactly 121*4+1=485 cycles.
   - ACK_ERR=0.
3. GO pulsed again 10 cycles after acceptance with DATA=24'h34FFFF -> ignored; the transfer still sends 34,0C,00. A second GO edge after END=1 sends 34,FF,FF.
4. GO held high continuously across two transfers -> exactly one transfer; END stays 1 after completion.
5. I2C_ACK_CHECK_EN defined, slave NACKs the address byte, DATA=24'h341201 -> checks:
   - ACK_ERR=1 at the first ACK slot q2.
   - STOP follows immediately; only byte 34 appears on the bus.
   - END low for (2+36+3+8)*4+1=197 cycles.
6. Macro undefined, same NACK stimulus -> all three bytes 34,12,01 sent; ACK_ERR stays 0; END low 485 cycles.

Source files
------------

// File: rtl/i2c_word_writer.sv
// rtl/i2c_word_writer.sv - serializes a 24-bit codec word as one I2C write transaction
// Define I2C_ACK_CHECK_EN to flag NACKs on ACK_ERR and cut the transfer short to STOP.
module i2c_word_writer #(
  parameter int CLK_DIV  = 16,
  parameter int IDLE_GAP = 8
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        GO,
  input  logic [23:0] DATA,
  output logic        END,
  output logic        ACK_ERR,
  output logic        I2C_SCLK,
  output logic        I2C_SDAT_OE,
  input  logic        I2C_SDAT_IN
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_GAP, S_DONE} state_t;

  localparam logic [15:0] LP_DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] LP_GAP_LAST = 16'(IDLE_GAP - 1);

  state_t      r_state;
  logic [15:0] r_div;
  logic [15:0] r_gap;
  logic [1:0]  r_q;
  logic [4:0]  r_bit;
  logic [23:0] r_shreg;
  logic        r_go_d;
  logic        r_end;
  logic        r_ack_err;
  logic        r_scl;
  logic        r_oe;

  logic w_qtick;
  logic w_accept;
  logic w_ack_slot;
  logic w_nack_stop;

  assign w_qtick    = (r_div == LP_DIV_LAST);
  assign w_accept   = GO & ~r_go_d & (r_state == S_IDLE);
  assign w_ack_slot = (r_bit == 5'd8) || (r_bit == 5'd17) || (r_bit == 5'd26);

`ifdef I2C_ACK_CHECK_EN
  // ACK_ERR is sticky within a transfer, so it doubles as the abort flag at q3
  assign w_nack_stop = w_ack_slot & r_ack_err;
`else
  logic w_unused_sda;
  assign w_nack_stop  = 1'b0;
  assign w_unused_sda = I2C_SDAT_IN;
`endif

  assign END         = r_end;
  assign ACK_ERR     = r_ack_err;
  assign I2C_SCLK    = r_scl;
  assign I2C_SDAT_OE = r_oe;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_div     <= 16'd0;
      r_gap     <= 16'd0;
      r_q       <= 2'd0;
      r_bit     <= 5'd0;
      r_shreg   <= 24'd0;
      r_go_d    <= 1'b0;
      r_end     <= 1'b1;
      r_ack_err <= 1'b0;
      r_scl     <= 1'b1;
      r_oe      <= 1'b0;
    end else begin
      r_go_d <= GO;
      r_div  <= w_qtick ? 16'd0 : r_div + 16'd1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shreg   <= DATA;
            r_end     <= 1'b0;
            r_ack_err <= 1'b0;
            r_div     <= 16'd0;
            r_q       <= 2'd0;
            r_bit     <= 5'd0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_qtick) begin
            if (r_q == 2'd0) begin
              r_oe <= 1'b1;
              r_q  <= 2'd1;
            end else begin
              r_scl   <= 1'b0;
              r_q     <= 2'd0;
              r_state <= S_BIT;
            end
          end
        end
        S_BIT: begin
          if (w_qtick) begin
            r_q <= r_q + 2'd1;
            case (r_q)
              2'd0: r_oe <= w_ack_slot ? 1'b0 : ~r_shreg[23];
              2'd1: r_scl <= 1'b1;
              2'd2: begin
`ifdef I2C_ACK_CHECK_EN
                if (w_ack_slot && I2C_SDAT_IN) r_ack_err <= 1'b1;
`endif
              end
              default: begin
                r_scl <= 1'b0;
                if (!w_ack_slot) r_shreg <= {r_shreg[22:0], 1'b0};
                if (r_bit == 5'd26 || w_nack_stop) r_state <= S_STOP;
                else r_bit <= r_bit + 5'd1;
              end
            endcase
          end
        end
        S_STOP: begin
          if (w_qtick) begin
            case (r_q)
              2'd0: begin
                r_oe <= 1'b1;
                r_q  <= 2'd1;
              end
              2'd1: begin
                r_scl <= 1'b1;
                r_q   <= 2'd2;
              end
              default: begin
                r_oe    <= 1'b0;
                r_q     <= 2'd0;
                r_gap   <= 16'd0;
                r_state <= S_GAP;
              end
            endcase
          end
        end
        S_GAP: begin
          if (w_qtick) begin
            if (r_gap == LP_GAP_LAST) r_state <= S_DONE;
            else r_gap <= r_gap + 16'd1;
          end
        end
        S_DONE: begin
          r_end   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_word_writer.sv
// tb/tb_i2c_word_writer.sv - scoreboard bench with an I2C slave/bus decoder for i2c_word_writer
module tb_i2c_word_writer;

  localparam int CD  = 4;
  localparam int GAP = 8;
`ifdef I2C_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        GO    = 1'b0;
  logic [23:0] DATA  = 24'h0;
  logic        END;
  logic        ACK_ERR;
  logic        I2C_SCLK;
  logic        I2C_SDAT_OE;
  logic        slave_pull = 1'b0;
  logic        sda;

  assign sda = ~I2C_SDAT_OE & ~slave_pull;

  i2c_word_writer #(.CLK_DIV(CD), .IDLE_GAP(GAP)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .GO         (GO),
    .DATA       (DATA),
    .END        (END),
    .ACK_ERR    (ACK_ERR),
    .I2C_SCLK   (I2C_SCLK),
    .I2C_SDAT_OE(I2C_SDAT_OE),
    .I2C_SDAT_IN(sda)
  );

  always #5 CLOCK = ~CLOCK;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_bytes[$];
  int         exp_len[$];
  logic       exp_err[$];
  bit         nack_addr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Bus decoder and slave, sampled on the falling clock edge
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       prev_end = 1'b1;
  int         bitcnt = 0;
  int         lowcnt = 0;
  logic [7:0] shift = 8'h0;
  bit         saw_stop = 1'b0;
  bit         aborted = 1'b0;

  always @(negedge CLOCK) begin
    if (RESET === 1'b1) begin
      aborted    = 1'b1;
      slave_pull = 1'b0;
    end
    if (prev_scl === 1'b1 && I2C_SCLK === 1'b1 && prev_sda === 1'b1 && sda === 1'b0) begin
      bitcnt   = 0;
      saw_stop = 1'b0;
    end
    if (prev_scl === 1'b1 && I2C_SCLK === 1'b1 && prev_sda === 1'b0 && sda === 1'b1)
      saw_stop = 1'b1;
    if (prev_scl === 1'b0 && I2C_SCLK === 1'b1) begin
      if (bitcnt % 9 < 8) begin
        shift = {shift[6:0], sda};
        if (bitcnt % 9 == 7) begin
          if (exp_bytes.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_byte: got %02h, expected none", shift);
          end else begin
            check("bus_byte", shift, exp_bytes.pop_front());
          end
        end
      end
      bitcnt++;
    end
    if (prev_scl === 1'b1 && I2C_SCLK === 1'b0) begin
      if (bitcnt % 9 == 8) begin
        slave_pull = !(nack_addr && (bitcnt / 9 == 0));
      end else if (bitcnt > 0 && bitcnt % 9 == 0) begin
        slave_pull = 1'b0;
        check("ack_err_slot", ACK_ERR, ACK_CHECK && nack_addr && (bitcnt / 9 == 1));
      end
    end
    if (prev_end === 1'b1 && END === 1'b0) begin
      lowcnt  = 1;
      aborted = 1'b0;
    end else if (END === 1'b0) begin
      lowcnt++;
    end
    if (prev_end === 1'b0 && END === 1'b1 && !aborted) begin
      if (exp_len.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_transfer: got END low %0d cycles, expected no transfer", lowcnt);
      end else begin
        check("end_low_cycles", lowcnt, exp_len.pop_front());
        check("ack_err_end", ACK_ERR, exp_err.pop_front());
        check("stop_seen", saw_stop, 1);
        check("bytes_left", exp_bytes.size(), 0);
      end
    end
    prev_scl = I2C_SCLK;
    prev_sda = sda;
    prev_end = END;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic launch(input logic [23:0] d, input bit push, input int len,
                        input logic err, input int nbytes);
    DATA = d;
    @(negedge CLOCK);
    GO = 1'b1;
    if (push) begin
      for (int i = 0; i < nbytes; i++) exp_bytes.push_back(d[23-8*i -: 8]);
      exp_len.push_back(len);
      exp_err.push_back(err);
    end
    @(negedge CLOCK);
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (END !== 1'b1 && n < 3000) begin
      @(negedge CLOCK);
      n++;
    end
    check({name, "_end_timeout"}, END, 1);
    cycles(3);
  endtask

  initial begin
    #2 RESET = 1'b1;
    cycles(3);
    check("reset_end", END, 1);
    check("reset_ack_err", ACK_ERR, 0);
    check("reset_sclk", I2C_SCLK, 1);
    check("reset_oe", I2C_SDAT_OE, 0);
    RESET = 1'b0;
    cycles(3);

    // abort a transfer in the middle of bit slot 5
    launch(24'h340C00, 1'b0, 0, 1'b0, 0);
    GO = 1'b0;
    cycles(CD * 24);
    check("busy_before_reset", END, 0);
    #1 RESET = 1'b1;
    #1;
    check("abort_sclk", I2C_SCLK, 1);
    check("abort_oe", I2C_SDAT_OE, 0);
    check("abort_end", END, 1);
    cycles(3);
    RESET = 1'b0;
    cycles(3);

    launch(24'h340C00, 1'b1, 485, 1'b0, 3);
    GO = 1'b0;
    wait_end("t2");

    // a GO edge while busy must be ignored
    launch(24'h340C00, 1'b1, 485, 1'b0, 3);
    GO = 1'b0;
    cycles(8);
    DATA = 24'h34FFFF;
    GO = 1'b1;
    cycles(2);
    GO = 1'b0;
    wait_end("t3a");
    launch(24'h34FFFF, 1'b1, 485, 1'b0, 3);
    GO = 1'b0;
    wait_end("t3b");

    // GO held high launches only once
    launch(24'h340C00, 1'b1, 485, 1'b0, 3);
    wait_end("t4");
    cycles(600);
    check("t4_end_idle", END, 1);
    check("t4_sclk_idle", I2C_SCLK, 1);
    GO = 1'b0;
    cycles(2);

    nack_addr = 1'b1;
    if (ACK_CHECK) launch(24'h341201, 1'b1, 197, 1'b1, 1);
    else launch(24'h341201, 1'b1, 485, 1'b0, 3);
    GO = 1'b0;
    wait_end("t5");
    nack_addr = 1'b0;

    check("exp_len_drained", exp_len.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
